// File: rtl/esm_fetch_feeder_if.sv
// Bus between the ESM fetch feeder, its instruction memory and the ESM core.
interface esm_fetch_feeder_if #(
    parameter int unsigned Instr_word_size = 32,
    parameter int unsigned AW              = 10
);
    logic                       go;
    logic [AW:0]                prog_len;
    logic [AW-1:0]              imem_addr;
    logic [Instr_word_size-1:0] imem_rdata;
    logic [Instr_word_size-1:0] Instr_in;
    logic                       ALUSrc;
    logic                       RegWrite;
    logic                       instr_valid;
    logic                       start;
    logic                       busy;
    logic                       done;

    modport master (
        input  go, prog_len, imem_rdata,
        output imem_addr, Instr_in, ALUSrc, RegWrite, instr_valid, start, busy, done
    );

    modport slave (
        output go, prog_len, imem_rdata,
        input  imem_addr, Instr_in, ALUSrc, RegWrite, instr_valid, start, busy, done
    );
endinterface

// File: rtl/esm_fetch_feeder.sv
// Streams a program from instruction memory into the ESM core with pre-decode and batch start pulses.
// Optional ESM_FEEDER_STALL_EN adds a stall input that freezes the whole pipeline.
module esm_fetch_feeder #(
    parameter int unsigned Instr_word_size = 32,
    parameter int unsigned bs              = 16,
    parameter int unsigned AW              = 10
) (
    input logic clk,
    input logic rst,
`ifdef ESM_FEEDER_STALL_EN
    input logic stall,
`endif
    esm_fetch_feeder_if.master bus
);
    localparam int unsigned CW = (bs > 1) ? $clog2(bs) : 1;
    localparam logic [Instr_word_size-1:0] NOP = Instr_word_size'(32'h0000_0013);
    localparam logic [AW:0] MAX_LEN = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FINISH} state_t;

    state_t                     state_q, state_d;
    logic [AW-1:0]              addr_q, addr_d;
    logic [AW-1:0]              last_q, last_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       rdv_q, rdv_d;
    logic                       vld_q, vld_d;
    logic [Instr_word_size-1:0] instr_q, instr_d;
    logic                       alu_q, alu_d;
    logic                       rw_q, rw_d;
    logic                       start_q, start_d;
    logic                       done_q, done_d;
    logic                       busy_q, busy_d;
    logic                       final_c;
    logic                       run;
    logic [Instr_word_size-1:0] src_data;

    function automatic logic [1:0] decode(input logic [6:0] op);
        case (op)
            7'b0110011:                     return 2'b01;
            7'b0010011, 7'b0000011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100111: return 2'b11;
            7'b0100011:                     return 2'b10;
            default:                        return 2'b00;
        endcase
    endfunction

`ifdef ESM_FEEDER_STALL_EN
    // Memory read data keeps flowing during a stall, so capture the word that was in flight.
    logic                       hold_vld_q;
    logic [Instr_word_size-1:0] hold_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_vld_q  <= 1'b0;
            hold_data_q <= '0;
        end else if (stall) begin
            if (!hold_vld_q) begin
                hold_vld_q  <= 1'b1;
                hold_data_q <= bus.imem_rdata;
            end
        end else begin
            hold_vld_q <= 1'b0;
        end
    end

    assign src_data = hold_vld_q ? hold_data_q : bus.imem_rdata;
    assign run      = !stall;
`else
    assign src_data = bus.imem_rdata;
    assign run      = 1'b1;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        rdv_d   = 1'b0;
        vld_d   = rdv_q;
        instr_d = NOP;
        alu_d   = 1'b1;
        rw_d    = 1'b0;
        start_d = 1'b0;
        done_d  = 1'b0;
        final_c = (state_q == DRAIN) && vld_q && !rdv_q;

        if (vld_q) begin
            cnt_d = cnt_q + CW'(1);
        end
        if (rdv_q) begin
            instr_d       = src_data;
            {alu_d, rw_d} = decode(src_data[6:0]);
        end

        case (state_q)
            IDLE: begin
                if (bus.go) begin
                    addr_d = '0;
                    cnt_d  = '0;
                    if (bus.prog_len == '0) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d = FETCH;
                        last_d  = (bus.prog_len > MAX_LEN) ? {AW{1'b1}}
                                                           : AW'(bus.prog_len - (AW+1)'(1));
                    end
                end
            end
            FETCH: begin
                rdv_d = 1'b1;
                if (addr_q == last_q) begin
                    state_d = DRAIN;
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
            DRAIN: begin
                if (final_c) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                end
            end
            FINISH: begin
                state_d = IDLE;
                addr_d  = '0;
            end
            default: state_d = IDLE;
        endcase

        start_d = vld_q && ((cnt_q == CW'(bs - 1)) || final_c);
        busy_d  = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
            rdv_q   <= 1'b0;
            vld_q   <= 1'b0;
            instr_q <= NOP;
            alu_q   <= 1'b1;
            rw_q    <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else if (run) begin
            state_q <= state_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            rdv_q   <= rdv_d;
            vld_q   <= vld_d;
            instr_q <= instr_d;
            alu_q   <= alu_d;
            rw_q    <= rw_d;
            start_q <= start_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.imem_addr = addr_q;
    assign bus.Instr_in  = instr_q;
    assign bus.ALUSrc    = alu_q;
    assign bus.RegWrite  = rw_q;
    assign bus.busy      = busy_q;
    assign bus.instr_valid = vld_q && run;
    assign bus.start       = start_q && run;
    assign bus.done        = done_q && run;
endmodule

// File: tb/tb_esm_fetch_feeder.sv
// Scoreboard bench for esm_fetch_feeder: directed programs, decode, batch starts, reset abort, clamping.
module tb_esm_fetch_feeder;
    localparam int unsigned W     = 32;
    localparam int unsigned BS    = 16;
    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 1 << AW;
    localparam logic [6:0]  OPS [12] = '{7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F,
                                         7'h67, 7'h23, 7'h63, 7'h73, 7'h0F, 7'h00};

    logic clk = 1'b0;
    logic rst;
    logic stall_now;
    always #5 clk = ~clk;

    esm_fetch_feeder_if #(.Instr_word_size(W), .AW(AW)) bus ();

`ifdef ESM_FEEDER_STALL_EN
    logic stall = 1'b0;
    assign stall_now = stall;
    esm_fetch_feeder #(.Instr_word_size(W), .bs(BS), .AW(AW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .bus(bus));
`else
    assign stall_now = 1'b0;
    esm_fetch_feeder #(.Instr_word_size(W), .bs(BS), .AW(AW)) dut (
        .clk(clk), .rst(rst), .bus(bus));
`endif

    logic [W-1:0] mem [DEPTH];
    always_ff @(posedge clk) bus.imem_rdata <= mem[bus.imem_addr];

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q [$];
    int start_log [$];
    int total_valid = 0;
    int done_cnt = 0;
    int gap_cnt = 0;
    int last_n = 0;
    int d0, base, g0, s0;
    logic prev_valid = 1'b0;
    logic prev_start = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference opcode table: {ALUSrc, RegWrite}.
    function automatic logic [1:0] ref_dec(input logic [W-1:0] w);
        case (w[6:0])
            7'h33:                                  return 2'b01;
            7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67: return 2'b11;
            7'h23:                                  return 2'b10;
            7'h63:                                  return 2'b00;
            default:                                return 2'b00;
        endcase
    endfunction

    // Output monitor: pops the scoreboard on every valid instruction and logs start pulses.
    always @(negedge clk) begin
        logic [W-1:0] e;
        logic [1:0]   d;
        if (rst) begin
            prev_valid = 1'b0;
            prev_start = 1'b0;
        end else begin
            if (bus.start) begin
                start_log.push_back(total_valid);
                chk("start_consecutive", prev_start, 0);
            end
            if (bus.done) begin
                done_cnt++;
                chk("done_with_start", bus.start, (last_n > 0) ? 1 : 0);
            end
            if (bus.instr_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_instr", bus.Instr_in, 64'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    d = ref_dec(e);
                    chk("instr", bus.Instr_in, e);
                    chk("alusrc", bus.ALUSrc, d[1]);
                    chk("regwrite", bus.RegWrite, d[0]);
                end
                total_valid++;
            end else if (!stall_now) begin
                if (prev_valid && exp_q.size() != 0) gap_cnt++;
                chk("idle_instr", bus.Instr_in, 32'h13);
                chk("idle_alusrc", bus.ALUSrc, 1);
                chk("idle_regwrite", bus.RegWrite, 0);
            end
            prev_valid = bus.instr_valid;
            prev_start = bus.start;
        end
    end

    // Queue the expected program and pulse go; returns just after the accepting edge.
    task automatic launch(input int n);
        int nc;
        nc = (n > int'(DEPTH)) ? int'(DEPTH) : n;
        last_n = nc;
        d0 = done_cnt;
        base = total_valid;
        g0 = gap_cnt;
        s0 = start_log.size();
        for (int k = 0; k < nc; k++) exp_q.push_back(mem[k]);
        @(posedge clk); #1;
        bus.go = 1'b1;
        bus.prog_len = (AW+1)'(n);
        @(posedge clk); #1;
        bus.go = 1'b0;
        bus.prog_len = (AW+1)'(5);
    endtask

    task automatic finish_prog(input int budget);
        int exp_starts [$];
        int ns;
        for (int i = 0; i < budget && done_cnt == d0; i++) @(posedge clk);
        chk("done_seen", done_cnt, d0 + 1);
        chk("queue_drained", exp_q.size(), 0);
        chk("no_gaps", gap_cnt, g0);
        for (int k = int'(BS); k <= last_n; k += int'(BS)) exp_starts.push_back(base + k);
        if (last_n % int'(BS) != 0) exp_starts.push_back(base + last_n);
        ns = start_log.size() - s0;
        chk("start_count", ns, exp_starts.size());
        for (int i = 0; i < ns && i < exp_starts.size(); i++)
            chk("start_pos", start_log[s0 + i], exp_starts[i]);
        @(negedge clk);
        chk("busy_after", bus.busy, 0);
        exp_q.delete();
    endtask

    task automatic chk_reset_outputs();
        chk("rst_valid", bus.instr_valid, 0);
        chk("rst_instr", bus.Instr_in, 32'h13);
        chk("rst_alusrc", bus.ALUSrc, 1);
        chk("rst_regwrite", bus.RegWrite, 0);
        chk("rst_start", bus.start, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_addr", bus.imem_addr, 0);
    endtask

    initial begin
        logic [W-1:0] w;
        rst = 1'b1;
        bus.go = 1'b0;
        bus.prog_len = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            w = $urandom();
            w[6:0] = OPS[i % 12];
            mem[i] = w;
        end
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h0020_81B3;
        mem[2] = 32'h0030_2023;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs();
        rst = 1'b0;

        // Three-instruction program with exact latency.
        launch(3);
        chk("busy_fetch", bus.busy, 1);
        @(negedge clk); chk("lat_e0", bus.instr_valid, 0);
        @(negedge clk); chk("lat_e1", bus.instr_valid, 0);
        @(negedge clk); chk("lat_e2", bus.instr_valid, 1);
        chk("lat_e2_word", bus.Instr_in, 32'h0050_0093);
        finish_prog(50);

        // Forty instructions across batches, with go pulsed while busy.
        launch(40);
        repeat (10) @(posedge clk);
        #1;
        chk("busy_mid", bus.busy, 1);
        bus.go = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.go = 1'b0;
        finish_prog(200);

        // Empty program.
        launch(0);
        @(negedge clk);
        chk("zero_done", bus.done, 1);
        chk("zero_start", bus.start, 0);
        chk("zero_addr", bus.imem_addr, 0);
        finish_prog(20);

        // Abort after five instructions, reset overriding go, then a fresh short program.
        launch(20);
        for (int i = 0; i < 200 && total_valid < base + 5; i++) @(posedge clk);
        chk("abort_reached", (total_valid >= base + 5) ? 1 : 0, 1);
        #1;
        rst = 1'b1;
        bus.go = 1'b1;
        bus.prog_len = (AW+1)'(7);
        exp_q.delete();
        @(posedge clk); #1;
        chk_reset_outputs();
        @(posedge clk); #1;
        chk("rst_overrides_go", bus.busy, 0);
        rst = 1'b0;
        bus.go = 1'b0;
        launch(2);
        finish_prog(50);

        // Length larger than memory is clamped to 2^AW.
        launch(1500);
        finish_prog(1200);

`ifdef ESM_FEEDER_STALL_EN
        launch(10);
        for (int i = 0; i < 100 && total_valid < base + 4; i++) @(posedge clk);
        #1;
        stall = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        stall = 1'b0;
        finish_prog(100);
`endif

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/esm_fetch_feeder.md
ESM_FETCH_FEEDER -- requirements
Module: esm_fetch_feeder

Interface
REQ-001 Parameter Instr_word_size, default 32, instruction width in bits.
REQ-002 Parameter bs, default 16, ESM buffer depth (power of two); one start pulse per bs delivered instructions.
REQ-003 Parameter AW, default 10, instruction-memory address width.
REQ-004 Port clk  input  1  single clock, all logic rising-edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port go  input  1  program launch request, sampled in IDLE only.
REQ-007 Port prog_len  input  AW+1  instruction count, latched on accepted go.
REQ-008 Port imem_addr  output  AW  registered instruction-memory read address.
REQ-009 Port imem_rdata  input  Instr_word_size  memory data, valid one cycle after imem_addr.
REQ-010 Port Instr_in  output  Instr_word_size  registered instruction to ESM core.
REQ-011 Port ALUSrc  output  1  registered decode: second operand is immediate.
REQ-012 Port RegWrite  output  1  registered decode: instruction writes rd.
REQ-013 Port instr_valid  output  1  Instr_in/ALUSrc/RegWrite carry a real instruction.
REQ-014 Port start  output  1  one-cycle pulse: buffer batch complete, issue may begin.
REQ-015 Port busy  output  1  high in every state except IDLE.
REQ-016 Port done  output  1  one-cycle pulse: program fully delivered.

Function
REQ-017 States SHALL be IDLE, FETCH, DRAIN, FINISH; IDLE->FETCH on go=1 with prog_len>0; IDLE->FINISH on go=1 with prog_len=0.
REQ-018 In FETCH, imem_addr SHALL start at 0 on the accepting edge and increment by 1 per edge until prog_len-1, then state SHALL go to DRAIN.
REQ-019 Latency: mem[k] SHALL appear on Instr_in with instr_valid=1 after edge E(k+2), E0 being the go-accepting edge; one instruction per cycle, no gaps.
REQ-020 DRAIN SHALL last until the final instruction is presented, then go to FINISH; FINISH SHALL last one cycle, assert done, return to IDLE.
REQ-021 Decode on opcode bits [6:0]: 0110011 -> ALUSrc=0,RegWrite=1; 0010011/0000011/0110111/0010111/1101111/1100111 -> ALUSrc=1,RegWrite=1; 0100011 -> ALUSrc=1,RegWrite=0; 1100011 -> ALUSrc=0,RegWrite=0; any other -> ALUSrc=0,RegWrite=0.
REQ-022 When instr_valid=0, Instr_in SHALL be 0x00000013, ALUSrc=1, RegWrite=0.
REQ-023 A delivered-count counter of width log2(bs) SHALL increment per valid instruction and wrap to 0 after bs-1.
REQ-024 start SHALL pulse in the cycle after the instruction that brings the counter to wrap, and in the cycle after the final instruction if that one did not wrap; never two consecutive cycles.
REQ-025 done SHALL assert in the same cycle as the final start pulse (FINISH); for prog_len=0, done SHALL pulse with no start.
REQ-026 go while busy=1 SHALL be ignored; prog_len SHALL only be sampled on the accepting edge.
REQ-027 prog_len > 2^AW SHALL be clamped to 2^AW; imem_addr SHALL never wrap within a program.

Reset
REQ-028 rst=1 at any edge SHALL force IDLE, imem_addr=0, counter=0, instr_valid=0, start=0, done=0, busy=0, Instr_in=0x00000013, ALUSrc=1, RegWrite=0, overriding go and mid-program state.
REQ-029 After rst deasserts, a new go SHALL restart from address 0 with no residue of the aborted program.

Configuration
REQ-030 Macro ESM_FEEDER_STALL_EN SHALL add input stall (1 bit); when stall=1, imem_addr, counter, state and output registers SHALL hold and instr_valid SHALL read 0 in that cycle, resuming with no lost or duplicated instruction.
REQ-031 Without ESM_FEEDER_STALL_EN the stall port SHALL not exist and delivery SHALL be uninterrupted.

Verification
REQ-032 Reset then go, prog_len=3, mem={0x00500093,0x002081B3,0x00302023} -> Instr_in in cycles E2..E4 with (ALUSrc,RegWrite)=(1,1),(0,1),(1,0); start and done pulse together once.
REQ-033 prog_len=40, bs=16 -> start pulses after instructions 16, 32 and 40 exactly; done with the third.
REQ-034 go with prog_len=0 -> done pulse next cycle, no start, imem_addr stays 0.
REQ-035 rst asserted after 5 instructions of prog_len=20, then go prog_len=2 -> outputs at reset values, second program delivers mem[0],mem[1] only.
REQ-036 go pulsed while busy -> ignored; with ESM_FEEDER_STALL_EN, stall for 3 cycles mid-program -> identical instruction sequence, 3-cycle delay.
